ble_tx_scheduler: RTL and testbench

//  Shares the single BLE UART transmit byte stream between N_REQ telemetry/ack requesters.

---
 rtl/ble_pkg.sv | 13 +
 rtl/ble_rr_arbiter.sv | 34 +++
 rtl/ble_tx_scheduler.sv | 139 +++++++++++++
 tb/tb_ble_tx_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// Shared BLE packet-path types: FSM state encoding and the newline framing byte.
// Used by both the TX scheduler and the RX packet framer.
package ble_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    TERM
  } ble_state_e;

  localparam logic [7:0] BLE_TERM_BYTE = 8'h0A;

endpackage

// File: rtl/ble_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr_i,
// wrapping modulo N.
module ble_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o,
  output logic          any_o
);

  int unsigned   cand;
  logic [PW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    win_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand     = (32'(ptr_i) + i) % N;
      cand_idx = cand[PW-1:0];
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        win_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ble_tx_scheduler.sv
// Round-robin TX scheduler: snapshots one requester's packet, streams it over a valid/ready
// byte interface with 0x0A payload bytes substituted, then appends the 0x0A terminator.
module ble_tx_scheduler
  import ble_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BYTES = 16,
  parameter logic [7:0]  SUB_BYTE  = 8'h0B
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ-1:0][7:0]               req_len_i,
  input  logic [N_REQ-1:0][MAX_BYTES-1:0][7:0] req_data_i,
  output logic [N_REQ-1:0]                    grant_o,
  output logic [N_REQ-1:0]                    done_o,
  output logic [7:0]                          tx_byte_o,
  output logic                                tx_valid_o,
  input  logic                                tx_ready_i,
  output logic                                busy_o,
  output logic                                sub_pulse_o
);

  localparam int unsigned PW     = $clog2(N_REQ);
  localparam int unsigned IW     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [7:0]  MaxLen = 8'(MAX_BYTES);

  ble_state_e                  state_q, state_d;
  logic [PW-1:0]               win_q, win_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  idx_q, idx_d;
  logic [MAX_BYTES-1:0][7:0]   buf_q, buf_d;
  logic [N_REQ-1:0]            grant_q, grant_d;
  logic [N_REQ-1:0]            done_q, done_d;
  logic                        sub_q, sub_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [PW-1:0]    arb_win;
  logic             arb_any;
  logic [7:0]       cur_len;
  logic [7:0]       raw_byte;
  logic [IW-1:0]    buf_idx;

  ble_rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .win_o (arb_win),
    .any_o (arb_any)
  );

  assign cur_len  = (req_len_i[arb_win] > MaxLen) ? MaxLen : req_len_i[arb_win];
  assign buf_idx  = idx_q[IW-1:0];
  assign raw_byte = buf_q[buf_idx];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    grant_d = '0;
    done_d  = '0;
    sub_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          win_d   = arb_win;
          buf_d   = req_data_i[arb_win];
          len_d   = cur_len;
          grant_d = arb_gnt;
          state_d = (cur_len != 8'd0) ? SEND : TERM;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          sub_d = (raw_byte == BLE_TERM_BYTE);
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = TERM;
        end
      end
      TERM: begin
        if (tx_ready_i) begin
          done_d[win_q] = 1'b1;
          ptr_d         = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          idx_d         = 8'd0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      sub_q   <= sub_d;
    end
  end

  // Valid and byte derive only from registered state, so reset drops them immediately.
  always_comb begin
    tx_byte_o = 8'h00;
    case (state_q)
      SEND:    tx_byte_o = (raw_byte == BLE_TERM_BYTE) ? SUB_BYTE : raw_byte;
      TERM:    tx_byte_o = BLE_TERM_BYTE;
      default: tx_byte_o = 8'h00;
    endcase
  end

  assign tx_valid_o  = (state_q != IDLE);
  assign busy_o      = (state_q != IDLE);
  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign sub_pulse_o = sub_q;

endmodule

// File: tb/tb_ble_tx_scheduler.sv
// Directed bench for ble_tx_scheduler: a table of single-requester packets plus hand-written
// round-robin, backpressure and mid-packet reset sequences.
module tb_ble_tx_scheduler;

  logic                  clk, rst;
  logic [3:0]            req;
  logic [3:0][7:0]       req_len;
  logic [3:0][15:0][7:0] req_data;
  logic [3:0]            grant, done;
  logic [7:0]            tx_byte;
  logic                  tx_valid, tx_ready, busy, sub_pulse;

  int tests, fails, cycle, sub_cnt, overlap, stalls, t0;
  logic [7:0] byte_q[$];
  int         xcyc_q[$];
  logic [3:0] grant_q[$];
  int         gcyc_q[$];
  logic [3:0] done_q[$];

  typedef struct {
    int         r;
    logic [7:0] len;
    logic [7:0] base;
    int         exp_n;
    int         exp_sub;
  } vec_t;
  vec_t vecs[7];

  ble_tx_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .req_len_i   (req_len),
    .req_data_i  (req_data),
    .grant_o     (grant),
    .done_o      (done),
    .tx_byte_o   (tx_byte),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .sub_pulse_o (sub_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_byte(logic [7:0] b);
    return (b == 8'h0A) ? 8'h0B : b;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(logic [1:0] r, logic [7:0] len, logic [7:0] base);
    for (int b = 0; b < 16; b++) req_data[r][b] = base + 8'(b);
    req_len[r] = len;
  endtask

  task automatic clear_logs();
    byte_q.delete();
    xcyc_q.delete();
    grant_q.delete();
    gcyc_q.delete();
    done_q.delete();
    sub_cnt = 0;
  endtask

  // Sample pre-edge handshake, advance one clock, then log post-edge pulses.
  task automatic cyc();
    logic       pv, pr;
    logic [7:0] pb;
    pv = tx_valid;
    pr = tx_ready;
    pb = tx_byte;
    @(posedge clk);
    #1;
    cycle++;
    if (pv && pr) begin
      byte_q.push_back(pb);
      xcyc_q.push_back(cycle);
    end
    if (pv && !pr) begin
      stalls++;
      check("hold_valid", int'(tx_valid), 1);
      check("hold_byte", int'(tx_byte), int'(pb));
    end
    if (grant != 4'b0) begin
      grant_q.push_back(grant);
      gcyc_q.push_back(cycle);
    end
    if (done != 4'b0) done_q.push_back(done);
    if (sub_pulse) sub_cnt++;
    if ((grant & done) != 4'b0) overlap++;
  endtask

  initial begin
    tests = 0; fails = 0; cycle = 0; overlap = 0; stalls = 0;
    rst = 1'b1; req = '0; req_len = '0; req_data = '0; tx_ready = 1'b1;
    vecs[0] = '{2, 8'd3,   8'h41, 3,  0};
    vecs[1] = '{0, 8'd0,   8'h30, 0,  0};
    vecs[2] = '{1, 8'd20,  8'h20, 16, 0};
    vecs[3] = '{3, 8'd2,   8'h0A, 2,  1};
    vecs[4] = '{1, 8'd16,  8'h00, 16, 1};
    vecs[5] = '{0, 8'd255, 8'hF0, 16, 0};
    vecs[6] = '{3, 8'd1,   8'hFF, 1,  0};
    #12;
    check("reset_outputs", int'({grant, done, tx_byte, tx_valid, busy, sub_pulse}), 0);
    rst = 1'b0;

    // Single-requester packets; payload is corrupted and req dropped right after grant.
    for (int v = 0; v < 7; v++) begin
      logic [3:0] rm;
      int         n;
      logic [7:0] eb;
      clear_logs();
      rm = 4'b0001 << vecs[v].r;
      n  = vecs[v].exp_n;
      load(2'(vecs[v].r), vecs[v].len, vecs[v].base);
      req = rm;
      t0  = cycle;
      for (int k = 0; k < 60 && done_q.size() == 0; k++) begin
        cyc();
        if (grant_q.size() != 0) begin
          req = '0;
          for (int b = 0; b < 16; b++) req_data[2'(vecs[v].r)][b] = 8'hEE;
        end
      end
      check($sformatf("v%0d_grant_cnt", v), grant_q.size(), 1);
      if (grant_q.size() > 0) begin
        check($sformatf("v%0d_grant", v), int'(grant_q[0]), int'(rm));
        check($sformatf("v%0d_latency", v), gcyc_q[0], t0 + 1);
      end
      check($sformatf("v%0d_done_cnt", v), done_q.size(), 1);
      if (done_q.size() > 0) check($sformatf("v%0d_done", v), int'(done_q[0]), int'(rm));
      check($sformatf("v%0d_nbytes", v), byte_q.size(), n + 1);
      for (int i = 0; i < byte_q.size() && i <= n; i++) begin
        eb = (i == n) ? 8'h0A : model_byte(vecs[v].base + 8'(i));
        check($sformatf("v%0d_byte%0d", v, i), int'(byte_q[i]), int'(eb));
      end
      if (xcyc_q.size() > 0)
        check($sformatf("v%0d_back2back", v), xcyc_q[xcyc_q.size() - 1] - xcyc_q[0], n);
      check($sformatf("v%0d_sub_cnt", v), sub_cnt, vecs[v].exp_sub);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
    end

    // All four requesters held high with ptr back at 0: order 0,1,2,3,0.
    rst = 1'b1; #1; rst = 1'b0;
    clear_logs();
    for (int r = 0; r < 4; r++) load(2'(r), 8'd1, 8'h80 + 8'(r));
    req = 4'hF;
    for (int k = 0; k < 40 && done_q.size() < 5; k++) cyc();
    req = '0;
    repeat (4) cyc();
    check("rr_grant_cnt", grant_q.size(), 5);
    for (int k = 0; k < 5 && k < grant_q.size(); k++)
      check($sformatf("rr_grant%0d", k), int'(grant_q[k]), 1 << (k % 4));
    for (int k = 0; k < 4 && k + 1 < gcyc_q.size(); k++)
      check($sformatf("rr_spacing%0d", k), gcyc_q[k + 1] - gcyc_q[k], 3);
    check("rr_nbytes", byte_q.size(), 10);
    for (int k = 0; k < 10 && k < byte_q.size(); k++)
      check($sformatf("rr_byte%0d", k), int'(byte_q[k]),
            (k % 2 == 1) ? 32'h0A : 32'h80 + (k / 2) % 4);

    // Backpressure with tx_ready pattern 1,0,0,1.
    clear_logs();
    stalls = 0;
    load(2'd2, 8'd4, 8'h50);
    req = 4'b0100;
    for (int k = 0; k < 60 && done_q.size() == 0; k++) begin
      tx_ready = (k % 4 == 0) || (k % 4 == 3);
      cyc();
      if (grant_q.size() != 0) req = '0;
    end
    tx_ready = 1'b1;
    check("bp_stalls_seen", int'(stalls > 0), 1);
    check("bp_nbytes", byte_q.size(), 5);
    for (int i = 0; i < 5 && i < byte_q.size(); i++)
      check($sformatf("bp_byte%0d", i), int'(byte_q[i]), (i == 4) ? 32'h0A : 32'h50 + i);
    check("bp_done_cnt", done_q.size(), 1);

    // Reset after 2 of 5 bytes, then restart with ptr and byte index back at 0.
    clear_logs();
    load(2'd1, 8'd5, 8'h70);
    load(2'd3, 8'd1, 8'h90);
    req = 4'b0010;
    for (int k = 0; k < 20 && byte_q.size() < 2; k++) begin
      cyc();
      if (grant_q.size() != 0) req = '0;
    end
    check("abort_bytes_before", byte_q.size(), 2);
    rst = 1'b1;
    #1;
    check("abort_valid", int'(tx_valid), 0);
    check("abort_busy", int'(busy), 0);
    cyc();
    cyc();
    check("abort_no_done", done_q.size(), 0);
    rst = 1'b0;
    clear_logs();
    req = 4'b1010;
    for (int k = 0; k < 40 && done_q.size() == 0; k++) begin
      cyc();
      if (grant_q.size() != 0) req = '0;
    end
    check("restart_grant_cnt", grant_q.size(), 1);
    if (grant_q.size() > 0) check("restart_grant", int'(grant_q[0]), 32'h2);
    check("restart_nbytes", byte_q.size(), 6);
    if (byte_q.size() > 0) check("restart_byte0", int'(byte_q[0]), 32'h70);
    if (done_q.size() > 0) check("restart_done", int'(done_q[0]), 32'h2);

    check("grant_done_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
